// File: rtl/vga_fb_pkg.sv
// Shared types and constants for the framebuffer arbiter: FSM states,
// RAM slot encoding and the default framebuffer geometry.
package vga_fb_pkg;

  localparam int FB_W_DEF = 160;
  localparam int FB_H_DEF = 120;
  localparam int FB_WORDS = FB_W_DEF * FB_H_DEF;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_e;

  typedef enum logic [1:0] {
    SLOT_NONE = 2'd0,
    SLOT_DISP = 2'd1,
    SLOT_CLR  = 2'd2,
    SLOT_WR   = 2'd3
  } slot_e;

endpackage

// File: rtl/vga_fb_addr_gen.sv
// Maps a 640x480 screen coordinate to a framebuffer word address using
// a constant shift-add in place of a multiplier.
module vga_fb_addr_gen #(
  parameter int FB_W       = 160,
  parameter int SCALE_LOG2 = 2,
  parameter int AW         = 15
) (
  input  logic [9:0]    i_pixel_x,
  input  logic [9:0]    i_pixel_y,
  output logic [AW-1:0] o_addr
);

  localparam logic [31:0] FB_W_V = 32'(FB_W);

  logic [AW-1:0] w_row;
  logic [AW-1:0] w_col;
  logic [AW-1:0] w_row_base;

  assign w_row = AW'(i_pixel_y >> SCALE_LOG2);
  assign w_col = AW'(i_pixel_x >> SCALE_LOG2);

  // Only the set bits of FB_W contribute a shifted copy of the row index.
  always_comb begin
    w_row_base = '0;
    for (int i = 0; i < AW; i++) begin
      if (FB_W_V[i]) w_row_base = w_row_base + (w_row << i);
    end
  end

  assign o_addr = w_row_base + w_col;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer scheduler: display scanout reads, full-screen
// clear engine and a generic write port, with a 2-cycle pixel pipeline.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int SCALE_LOG2 = 2,
  parameter int DW         = 8,
  parameter int AW         = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [9:0]      pixel_x,
  input  logic [9:0]      pixel_y,
  input  logic            video_on,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_data,
  output logic            wr_drop,
  input  logic            clr_start,
  input  logic [DW-1:0]   clr_color,
  output logic            clr_busy,
  output logic            clr_done,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_we,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic [DW-1:0]   pix_data,
  output logic            pix_valid,
  output fb_state_e       dbg_state
);

  localparam int            WORDS     = FB_W * FB_H;
  localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

  fb_state_e     r_state;
  fb_state_e     w_next;
  slot_e         w_slot;
  logic          w_disp_slot;
  logic [AW-1:0] w_disp_addr;
  logic          w_wr_ready;
  logic          w_drop;
  logic          w_clr_busy;
  logic          w_clr_done;
  logic [AW-1:0] r_clr_addr;
  logic [DW-1:0] r_clr_color;
  logic [1:0]    r_vid;
  logic          r_rd_d;
  logic [DW-1:0] r_pix;

  vga_fb_addr_gen #(
    .FB_W      (FB_W),
    .SCALE_LOG2(SCALE_LOG2),
    .AW        (AW)
  ) u_addr_gen (
    .i_pixel_x(pixel_x),
    .i_pixel_y(pixel_y),
    .o_addr   (w_disp_addr)
  );

  assign w_disp_slot = video_on && (pixel_x[SCALE_LOG2-1:0] == '0);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Writer handshake: a transfer happens in any cycle with wr_valid && wr_ready;
  // wr_ready never depends on wr_valid, and the writer holds addr/data until then.
  always_comb begin
    w_next     = r_state;
    w_slot     = SLOT_NONE;
    w_wr_ready = 1'b0;
    w_drop     = 1'b0;
    w_clr_busy = 1'b0;
    w_clr_done = 1'b0;
    if (rst) begin
      if (w_disp_slot) w_slot = SLOT_DISP;
      case (r_state)
        IDLE: begin
          w_wr_ready = !w_disp_slot;
          if (wr_valid && w_wr_ready) begin
            w_slot = SLOT_WR;
            w_drop = (wr_addr > LAST_ADDR);
          end
          if (clr_start) w_next = CLEAR;
        end
        CLEAR: begin
          w_clr_busy = 1'b1;
          if (!w_disp_slot) begin
            w_slot = SLOT_CLR;
            if (r_clr_addr == LAST_ADDR) begin
              w_clr_done = 1'b1;
              w_next     = IDLE;
            end
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (w_slot)
      SLOT_DISP: mem_addr = w_disp_addr;
      SLOT_CLR: begin
        mem_addr  = r_clr_addr;
        mem_we    = 1'b1;
        mem_wdata = r_clr_color;
      end
      SLOT_WR: begin
        mem_addr  = wr_addr;
        mem_we    = !w_drop;
        mem_wdata = wr_data;
      end
      default: mem_addr = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_clr_addr  <= '0;
      r_clr_color <= '0;
      r_vid       <= '0;
      r_rd_d      <= 1'b0;
      r_pix       <= '0;
    end else begin
      r_vid  <= {r_vid[0], video_on};
      r_rd_d <= (w_slot == SLOT_DISP);
      // Read data arrives the cycle after the display slot.
      if (r_rd_d) r_pix <= mem_rdata;
      if (r_state == IDLE && clr_start) begin
        r_clr_color <= clr_color;
        r_clr_addr  <= '0;
      end else if (w_slot == SLOT_CLR) begin
        r_clr_addr <= r_clr_addr + 1'b1;
      end
    end
  end

  assign wr_ready  = w_wr_ready;
  assign wr_drop   = w_drop;
  assign clr_busy  = w_clr_busy;
  assign clr_done  = w_clr_done;
  assign pix_valid = r_vid[1] & rst;
  assign pix_data  = r_pix & {DW{pix_valid}};
  assign dbg_state = r_state;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural 1-cycle-latency RAM.
module tb_vga_fb_arbiter;
  import vga_fb_pkg::*;

  localparam int FB_W       = 160;
  localparam int FB_H       = 120;
  localparam int SCALE_LOG2 = 2;
  localparam int DW         = 8;
  localparam int AW         = 15;

  logic          clk;
  logic          rst;
  logic [9:0]    pixel_x;
  logic [9:0]    pixel_y;
  logic          video_on;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_drop;
  logic          clr_start;
  logic [DW-1:0] clr_color;
  logic          clr_busy;
  logic          clr_done;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  fb_state_e     dbg_state;

  logic [DW-1:0] fb [0:(1<<AW)-1];

  int n_checks = 0;
  int n_errors = 0;

  vga_fb_arbiter #(
    .FB_W(FB_W), .FB_H(FB_H), .SCALE_LOG2(SCALE_LOG2), .DW(DW), .AW(AW)
  ) dut (
    .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_drop(wr_drop),
    .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy),
    .clr_done(clr_done), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .pix_data(pix_data),
    .pix_valid(pix_valid), .dbg_state(dbg_state)
  );

  // Clock and RAM model
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (mem_we) fb[mem_addr] <= mem_wdata;
    mem_rdata <= fb[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_pix [15];
  logic       exp_pv  [15];
  logic       exp_rdy [8];
  logic [7:0] before_drop;
  int         k;
  int         exp_ca;
  int         done_cnt;
  int         bad;
  int         fb_bad;
  logic       timeout;
  logic       found;

  initial begin
    exp_pix = '{8'h00, 8'h00, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22,
                8'h22, 8'h22, 8'h33, 8'h33, 8'h33, 8'h33, 8'h00};
    exp_pv  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_rdy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    // Reset with a write request held
    rst = 1'b0; pixel_x = '0; pixel_y = '0; video_on = 1'b0;
    wr_valid = 1'b1; wr_addr = '0; wr_data = 8'h11;
    clr_start = 1'b0; clr_color = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_clr_busy", clr_busy, 0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));

    @(negedge clk); rst = 1'b1; #1;
    chk("rel_wr_ready", wr_ready, 1);
    chk("rel_mem_we", mem_we, 1);
    chk("rel_mem_addr", mem_addr, 0);
    chk("rel_mem_wdata", mem_wdata, 8'h11);

    for (int i = 1; i < 4; i++) begin
      @(negedge clk); wr_addr = AW'(i); wr_data = 8'(17 * (i + 1)); #1;
    end
    @(negedge clk); wr_valid = 1'b0; #1;
    chk("preload", {fb[0], fb[1], fb[2], fb[3]}, 32'h11223344);

    // Scan line y=0 through the 2-cycle pixel pipeline
    for (int x = 0; x < 15; x++) begin
      @(negedge clk); pixel_y = '0; pixel_x = 10'(x); video_on = (x < 12); #1;
      chk("scan_pix_valid", pix_valid, exp_pv[x]);
      chk("scan_pix_data", pix_data, exp_pix[x]);
      if (x == 0) begin
        chk("scan_addr_x0", mem_addr, 0);
        chk("scan_we_x0", mem_we, 0);
      end
      if (x == 4) chk("scan_addr_x4", mem_addr, 1);
      if (x == 8) chk("scan_addr_x8", mem_addr, 2);
    end

    @(negedge clk); pixel_y = 10'd5; pixel_x = 10'd8; video_on = 1'b1; #1;
    chk("addr_y5_x8", mem_addr, 162);
    @(negedge clk); pixel_y = 10'd479; pixel_x = 10'd636; #1;
    chk("addr_last", mem_addr, 19199);
    @(negedge clk); pixel_x = 10'd637; #1;
    chk("free_wr_ready", wr_ready, 1);

    // Writer stalled by display slots
    wr_addr = AW'(100); wr_data = 8'h77;
    for (int x = 4; x < 12; x++) begin
      @(negedge clk); pixel_y = '0; pixel_x = 10'(x); video_on = 1'b1; wr_valid = 1'b1; #1;
      chk("stall_wr_ready", wr_ready, exp_rdy[x-4]);
      if (x == 4) chk("stall_we_x4", mem_we, 0);
      if (x == 5) chk("stall_addr_x5", {mem_we, 15'(mem_addr)}, {1'b1, 15'd100});
    end
    @(negedge clk); wr_valid = 1'b0; video_on = 1'b0; #1;
    chk("stall_ram", fb[100], 8'h77);

    // Out-of-range write is dropped
    before_drop = fb[19200];
    @(negedge clk); wr_valid = 1'b1; wr_addr = AW'(19200); wr_data = 8'hEE; #1;
    chk("drop_ready", wr_ready, 1);
    chk("drop_pulse", wr_drop, 1);
    chk("drop_we", mem_we, 0);
    @(negedge clk); wr_addr = AW'(19199); wr_data = 8'h99; #1;
    chk("edge_drop", wr_drop, 0);
    chk("edge_we", mem_we, 1);
    @(negedge clk); wr_valid = 1'b0; #1;
    chk("drop_one_cycle", wr_drop, 0);
    chk("drop_ram", fb[19200], before_drop);
    chk("edge_ram", fb[19199], 8'h99);

    // Full clear with a concurrent writer transfer
    @(negedge clk); clr_start = 1'b1; clr_color = 8'hA5;
    wr_valid = 1'b1; wr_addr = AW'(300); wr_data = 8'h3C; #1;
    chk("clr_wr_we", mem_we, 1);
    chk("clr_wr_addr", mem_addr, 300);
    chk("clr_wr_ready", wr_ready, 1);
    chk("clr_busy_pre", clr_busy, 0);
    @(negedge clk); clr_start = 1'b0; clr_color = '0;
    wr_addr = AW'(19200); wr_data = 8'h55; #1;
    chk("clr_first_busy", clr_busy, 1);
    chk("clr_first_ready", wr_ready, 0);
    chk("clr_first_addr", {mem_we, 15'(mem_addr), mem_wdata}, {1'b1, 15'd0, 8'hA5});
    chk("clr_state", 32'(dbg_state), 32'(CLEAR));
    chk("clr_wr_landed", fb[300], 8'h3C);

    exp_ca = 1; k = 0; done_cnt = 0; bad = 0; timeout = 1'b0;
    while (!timeout) begin
      @(negedge clk);
      pixel_x = 10'(k % 640); pixel_y = '0; video_on = 1'b1;
      clr_start = (k == 1000);
      clr_color = (k == 1000) ? 8'h5B : 8'h00;
      #1;
      if (!clr_busy) break;
      if (wr_ready) bad++;
      if (pixel_x[1:0] == 2'd0) begin
        if (mem_we || mem_addr != AW'(pixel_x >> 2)) bad++;
      end else begin
        if (!mem_we || mem_addr != AW'(exp_ca) || mem_wdata != 8'hA5) bad++;
        exp_ca++;
      end
      if (clr_done) begin
        done_cnt++;
        if (mem_addr != AW'(19199)) bad++;
      end
      k++;
      if (k > 40000) timeout = 1'b1;
    end
    chk("clr_timeout", timeout, 0);
    chk("clr_seq_bad", bad, 0);
    chk("clr_done_cnt", done_cnt, 1);
    chk("clr_words", exp_ca, 19200);
    chk("clr_idle", 32'(dbg_state), 32'(IDLE));
    chk("clr_done_low", clr_done, 0);
    @(negedge clk); wr_valid = 1'b0; video_on = 1'b0; clr_start = 1'b0; #1;
    fb_bad = 0;
    for (int i = 0; i < FB_W * FB_H; i++) if (fb[i] !== 8'hA5) fb_bad++;
    chk("clr_ram", fb_bad, 0);

    // Reset in the middle of a clear
    @(negedge clk); clr_start = 1'b1; clr_color = 8'h3C; #1;
    @(negedge clk); clr_start = 1'b0; #1;
    found = 1'b0; k = 0;
    while (k < 6000) begin
      @(negedge clk); #1;
      if (mem_we && mem_addr == AW'(5000)) begin
        found = 1'b1;
        break;
      end
      k++;
    end
    chk("abort_reached", found, 1);
    @(negedge clk); rst = 1'b0; #1;
    chk("abort_busy", clr_busy, 0);
    chk("abort_done", clr_done, 0);
    chk("abort_we", mem_we, 0);
    @(negedge clk); #1;
    chk("abort_done2", clr_done, 0);
    @(negedge clk); rst = 1'b1; #1;
    chk("abort_state", 32'(dbg_state), 32'(IDLE));
    chk("abort_idle_busy", clr_busy, 0);
    chk("abort_wr_ready", wr_ready, 1);
    @(negedge clk); clr_start = 1'b1; clr_color = 8'h66; #1;
    @(negedge clk); clr_start = 1'b0; #1;
    chk("restart_busy", clr_busy, 1);
    chk("restart_addr0", {mem_we, 15'(mem_addr), mem_wdata}, {1'b1, 15'd0, 8'h66});
    @(negedge clk); #1;
    chk("restart_addr1", mem_addr, 1);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
